// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/EXEC/MEM/WB/EXC sequencer.
// Control outputs decode the current state, the latched instruction fields, mem_ready and Zero.
module multicycle_control #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned EXC_EN  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  input  logic               Zero,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic [1:0]         PCSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               ALUSrc1,
  output logic               ALUSrc2,
  output logic               ExtOp,
  output logic               LuOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               exc,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_EXC    = 3'd5
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_SLTI = 6'h0a;
  localparam logic [5:0] OP_SLTU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic [3:0] alu_op;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0f, 6'h23, 6'h2b: is_legal = 1'b1;
      default:                    is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    PCSrc       = 2'b00;
    RegDst      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrc1     = 1'b0;
    ALUSrc2     = 1'b0;
    ExtOp       = 1'b0;
    LuOp        = 1'b0;
    alu_op      = 4'b0000;
    exc         = 1'b0;
    state       = 3'd0;

    // Reset masks every output; the register block handles the state itself.
    if (!reset) begin
      state = 3'(state_q);
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          op_d    = OpCode;
          funct_d = Funct;
          if (is_legal(OpCode)) state_d = S_EXEC;
          else                  state_d = (EXC_EN != 0) ? S_EXC : S_FETCH;
        end
        S_EXEC: begin
          alu_op[3] = op_q[0];
          case (op_q)
            OP_R: begin
              if (funct_q == FN_JR || funct_q == FN_JALR) begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                state_d = S_FETCH;
                if (funct_q == FN_JALR) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'b01;
                  MemtoReg = 2'b10;
                end
              end else begin
                alu_op[2:0] = 3'b010;
                ALUSrc1     = (funct_q == 6'h00) || (funct_q == 6'h02) || (funct_q == 6'h03);
                state_d     = S_WB;
              end
            end
            OP_J, OP_JAL: begin
              PCWrite = 1'b1;
              PCSrc   = 2'b01;
              state_d = S_FETCH;
              if (op_q == OP_JAL) begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
              end
            end
            OP_BEQ: begin
              alu_op[2:0] = 3'b001;
              PCWriteCond = 1'b1;
              PCWrite     = Zero;
              state_d     = S_FETCH;
            end
            default: begin
              // Only legal I-type ALU ops and lw/sw reach here.
              ALUSrc2 = 1'b1;
              ExtOp   = (op_q != OP_ANDI);
              LuOp    = (op_q == OP_LUI);
              if (op_q == OP_ANDI)                         alu_op[2:0] = 3'b100;
              else if (op_q == OP_SLTI || op_q == OP_SLTU) alu_op[2:0] = 3'b101;
              else                                         alu_op[2:0] = 3'b000;
              state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            end
          endcase
        end
        S_MEM: begin
          IorD = 1'b1;
          if (op_q == OP_SW) MemWrite = 1'b1;
          else               MemRead  = 1'b1;
          if (mem_ready) state_d = (op_q == OP_SW) ? S_FETCH : S_WB;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = (op_q == OP_R) ? 2'b01 : 2'b00;
          MemtoReg = (op_q == OP_LW) ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
        end
        S_EXC: begin
          exc     = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = 2'b11;
          state_d = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  assign ALUOp = ALUOP_W'(alu_op);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control bundles, hand-derived.
// A second instance with EXC_EN=0 and a wider ALUOp covers the no-trap and zero-extension cases.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       mem_ready, Zero;

  logic       IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, RegWrite;
  logic [1:0] PCSrc, RegDst, MemtoReg;
  logic       ALUSrc1, ALUSrc2, ExtOp, LuOp, exc;
  logic [3:0] ALUOp;
  logic [2:0] state;

  logic       IRWrite_0, PCWrite_0, PCWriteCond_0, IorD_0, MemRead_0, MemWrite_0, RegWrite_0;
  logic [1:0] PCSrc_0, RegDst_0, MemtoReg_0;
  logic       ALUSrc1_0, ALUSrc2_0, ExtOp_0, LuOp_0, exc_0;
  logic [4:0] ALUOp_0;
  logic [2:0] state_0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(4), .EXC_EN(1)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready), .Zero(Zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .ExtOp(ExtOp), .LuOp(LuOp), .ALUOp(ALUOp), .exc(exc), .state(state)
  );

  multicycle_control #(.ALUOP_W(5), .EXC_EN(0)) dut0 (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready), .Zero(Zero),
    .IRWrite(IRWrite_0), .PCWrite(PCWrite_0), .PCWriteCond(PCWriteCond_0), .IorD(IorD_0),
    .MemRead(MemRead_0), .MemWrite(MemWrite_0), .RegWrite(RegWrite_0), .PCSrc(PCSrc_0),
    .RegDst(RegDst_0), .MemtoReg(MemtoReg_0), .ALUSrc1(ALUSrc1_0), .ALUSrc2(ALUSrc2_0),
    .ExtOp(ExtOp_0), .LuOp(LuOp_0), .ALUOp(ALUOp_0), .exc(exc_0), .state(state_0)
  );

  // Observed bundle layout, MSB first.
  logic [24:0] obs;
  assign obs = {IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, RegWrite,
                PCSrc, RegDst, MemtoReg, ALUSrc1, ALUSrc2, ExtOp, LuOp, ALUOp, exc, state};

  localparam logic [24:0] IRW  = 25'd1 << 24;
  localparam logic [24:0] PCW  = 25'd1 << 23;
  localparam logic [24:0] PCC  = 25'd1 << 22;
  localparam logic [24:0] IOD  = 25'd1 << 21;
  localparam logic [24:0] MRD  = 25'd1 << 20;
  localparam logic [24:0] MWR  = 25'd1 << 19;
  localparam logic [24:0] RGW  = 25'd1 << 18;
  localparam logic [24:0] AS1  = 25'd1 << 11;
  localparam logic [24:0] AS2  = 25'd1 << 10;
  localparam logic [24:0] EXT  = 25'd1 << 9;
  localparam logic [24:0] LUO  = 25'd1 << 8;
  localparam logic [24:0] EXCB = 25'd1 << 3;

  function automatic logic [24:0] pcsrc(input int unsigned v);  return 25'(v) << 16; endfunction
  function automatic logic [24:0] regdst(input int unsigned v); return 25'(v) << 14; endfunction
  function automatic logic [24:0] m2r(input int unsigned v);    return 25'(v) << 12; endfunction
  function automatic logic [24:0] aluop(input int unsigned v);  return 25'(v) << 4;  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at posedge+1: settle, compare this cycle's outputs, advance one clock.
  task automatic step(input string tag, input logic [24:0] exp);
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // FETCH and DECODE of one instruction, then scramble live fields so EXEC+ must use latched ones.
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    OpCode    = op;
    Funct     = fn;
    mem_ready = 1'b1;
    step({tag, "_fetch"}, IRW | PCW | MRD | 25'd0);
    step({tag, "_decode"}, 25'd1);
    OpCode = ~op;
    Funct  = ~fn;
  endtask

  initial begin
    reset = 1'b1; OpCode = 6'h00; Funct = 6'h00; mem_ready = 1'b0; Zero = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    step("in_reset", 25'd0);
    reset = 1'b0;
    mem_ready = 1'b0;
    step("post_reset", MRD | 25'd0);

    // add: 4 cycles, ALUOp=2 in EXEC, RegDst=01 in WB
    fetch_decode("add", 6'h00, 6'h20);
    #1;
    check("add_aluop_w5", 32'(ALUOp_0), 32'h02);
    #0 step("add_exec", aluop(2) | 25'd2);
    step("add_wb", RGW | regdst(1) | 25'd4);

    // sll-style funct 0 selects shamt on ALU input 1
    fetch_decode("sll", 6'h00, 6'h00);
    step("sll_exec", AS1 | aluop(2) | 25'd2);
    step("sll_wb", RGW | regdst(1) | 25'd4);

    // lw with two wait cycles in MEM: 7 cycles total
    fetch_decode("lw", 6'h23, 6'h00);
    step("lw_exec", AS2 | EXT | aluop(8) | 25'd2);
    mem_ready = 1'b0;
    step("lw_mem0", IOD | MRD | 25'd3);
    step("lw_mem1", IOD | MRD | 25'd3);
    mem_ready = 1'b1;
    step("lw_mem2", IOD | MRD | 25'd3);
    step("lw_wb", RGW | m2r(1) | 25'd4);

    // sw: 4 cycles, MemWrite in MEM
    fetch_decode("sw", 6'h2b, 6'h00);
    step("sw_exec", AS2 | EXT | aluop(8) | 25'd2);
    step("sw_mem", IOD | MWR | 25'd3);

    // beq taken / not taken
    fetch_decode("beq1", 6'h04, 6'h00);
    Zero = 1'b1;
    step("beq1_exec", PCC | PCW | aluop(1) | 25'd2);
    fetch_decode("beq0", 6'h04, 6'h00);
    Zero = 1'b0;
    step("beq0_exec", PCC | aluop(1) | 25'd2);

    // jal and j
    fetch_decode("jal", 6'h03, 6'h00);
    step("jal_exec", PCW | pcsrc(1) | RGW | regdst(2) | m2r(2) | aluop(8) | 25'd2);
    fetch_decode("j", 6'h02, 6'h00);
    step("j_exec", PCW | pcsrc(1) | 25'd2);

    // jr and jalr
    fetch_decode("jr", 6'h00, 6'h08);
    step("jr_exec", PCW | pcsrc(2) | 25'd2);
    fetch_decode("jalr", 6'h00, 6'h09);
    step("jalr_exec", PCW | pcsrc(2) | RGW | regdst(1) | m2r(2) | 25'd2);

    // I-type ALU variants
    fetch_decode("andi", 6'h0c, 6'h00);
    step("andi_exec", AS2 | aluop(4) | 25'd2);
    step("andi_wb", RGW | 25'd4);
    fetch_decode("lui", 6'h0f, 6'h00);
    #1;
    check("lui_aluop_w5", 32'(ALUOp_0), 32'h08);
    #0 step("lui_exec", AS2 | EXT | LUO | aluop(8) | 25'd2);
    step("lui_wb", RGW | 25'd4);
    fetch_decode("sltiu", 6'h0b, 6'h00);
    step("sltiu_exec", AS2 | EXT | aluop(13) | 25'd2);
    step("sltiu_wb", RGW | 25'd4);

    // illegal opcode: trap instance goes to EXC, the other retires to FETCH
    OpCode = 6'h3f; Funct = 6'h00; mem_ready = 1'b1;
    step("ill_fetch", IRW | PCW | MRD | 25'd0);
    #1;
    check("ill_decode_noexc", 32'({exc_0, state_0}), 32'h1);
    #0 step("ill_decode", 25'd1);
    #1;
    check("ill_noexc_fetch", 32'({exc_0, state_0}), 32'h0);
    #0 step("ill_exc", EXCB | PCW | pcsrc(3) | 25'd5);
    step("ill_back", IRW | PCW | MRD | 25'd0);

    // resync both instances, then abort sw in MEM with reset
    reset = 1'b1;
    step("resync", 25'd0);
    reset = 1'b0;
    fetch_decode("swr", 6'h2b, 6'h00);
    mem_ready = 1'b0;
    step("swr_exec", AS2 | EXT | aluop(8) | 25'd2);
    reset = 1'b1;
    step("swr_reset", 25'd0);
    reset = 1'b0;
    step("swr_after0", MRD | 25'd0);
    step("swr_after1", MRD | 25'd0);
    mem_ready = 1'b1;
    step("swr_fetch", IRW | PCW | MRD | 25'd0);
    step("swr_decode", 25'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
